// File: rtl/grom_boot_loader.sv
// grom_boot_loader
//   Boot loader and RAM-port sequencer for the grom8 system. While a program
//   image streams in (length lo, length hi, then N data bytes), the loader owns
//   the single RAM port and holds the CPU in reset. Once the image is written
//   and a short reset-hold interval has elapsed, the port is handed back to the
//   CPU and its reset is released.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   load_start        : reload request, honoured only while the CPU runs
//   rx_data/rx_valid  : byte stream in; rx_ready marks acceptance
//   cpu_addr, cpu_data_out, cpu_we, cpu_ioreq : CPU side of the RAM port
//   cpu_data_in       : RAM read data returned to the CPU
//   cpu_reset         : registered reset to the CPU
//   mem_addr, mem_data_in, mem_we, mem_data_out : RAM side of the port
//   busy              : high whenever the CPU does not own the port
//   load_done         : one-cycle pulse on entering RUN after a load
module grom_boot_loader #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int BOOT_ON_RESET = 1,
  parameter int RESET_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_we,
  input  logic                  cpu_ioreq,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  load_done
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);
  localparam logic [CNT_W-1:0]  MAX_LEN   = CNT_W'(1) << ADDR_WIDTH;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    LEN_LO  = 3'd0,
    LEN_HI  = 3'd1,
    DATA    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } state_t;

  state_t                state, state_d;
  logic [HOLD_W-1:0]     hold;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      len;
  logic [CNT_W-1:0]      len_req;
  logic [DATA_WIDTH-1:0] len_lo;
  logic [2*DATA_WIDTH-1:0] len_raw;
  logic                  unused_len_bits;
  logic                  boot_req;   // first RELEASE after reset branches to LEN_LO
  logic                  from_load;  // current RELEASE was entered from a header/data load
  logic                  xfer;

  // Lengths beyond the RAM size are clamped so addresses never wrap.
  function automatic logic [CNT_W-1:0] sat_len(input logic [CNT_W-1:0] n);
    return (n > MAX_LEN) ? MAX_LEN : n;
  endfunction

  assign len_raw         = {rx_data, len_lo};
  assign unused_len_bits = ^len_raw[2*DATA_WIDTH-1:CNT_W];
  assign len_req         = sat_len(len_raw[CNT_W-1:0]);
  assign cnt_inc         = cnt + CNT_W'(1);

  assign rx_ready    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign xfer        = rx_valid & rx_ready;
  assign busy        = (state != RUN);
  assign cpu_data_in = mem_data_out;

  always_comb begin
    state_d = state;
    case (state)
      LEN_LO:  if (xfer) state_d = LEN_HI;
      LEN_HI:  if (xfer) state_d = (len_req == '0) ? RELEASE : DATA;
      DATA:    if (xfer && (cnt_inc == len)) state_d = RELEASE;
      RELEASE: begin
        if (boot_req)                state_d = LEN_LO;
        else if (hold == HOLD_LAST)  state_d = RUN;
      end
      RUN:     if (load_start) state_d = LEN_LO;
      default: state_d = RELEASE;
    endcase
  end

  // RAM port ownership: CPU in RUN, loader otherwise.
  always_comb begin
    mem_addr    = cnt[ADDR_WIDTH-1:0];
    mem_data_in = rx_data;
    mem_we      = rx_valid & (state == DATA);
    if (state == RUN) begin
      mem_addr    = cpu_addr;
      mem_data_in = cpu_data_out;
      mem_we      = cpu_we & ~cpu_ioreq;
    end
  end

  // Control registers: state, counters, CPU reset and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RELEASE;
      hold      <= '0;
      cnt       <= '0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      boot_req  <= (BOOT_ON_RESET != 0);
      from_load <= 1'b0;
    end else begin
      state     <= state_d;
      cpu_reset <= (state_d != RUN);
      load_done <= (state == RELEASE) && (state_d == RUN) && from_load;
      boot_req  <= 1'b0;
      hold      <= ((state == RELEASE) && (state_d == RELEASE)) ? hold + HOLD_W'(1) : '0;
      if (state == LEN_HI && xfer)    from_load <= 1'b1;
      else if (state_d == RUN)        from_load <= 1'b0;
      if (state == LEN_HI && xfer)    cnt <= '0;
      else if (state == DATA && xfer) cnt <= cnt_inc;
    end
  end

  // Header capture: length bytes only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == LEN_LO && xfer) len_lo <= rx_data;
    if (state == LEN_HI && xfer) len    <= len_req;
  end

endmodule

// File: doc/grom_boot_loader.md
# grom_boot_loader

Boot loader and RAM-port sequencer for the grom8 system. It sits between `grom_cpu`, `ram_memory` and a byte-stream source such as a UART receiver. While it loads a program image into the 4K×8 RAM, it owns the single RAM port and holds the CPU in reset. After the load it hands the port back to the CPU and releases reset.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: RAM address width.
- `DATA_WIDTH`, 8: RAM and stream data width.
- `BOOT_ON_RESET`, 1: 1 = enter loading after reset; 0 = go straight to running the CPU.
- `RESET_HOLD`, 2: cycles `cpu_reset` stays high after the last byte (≥1).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `load_start` in 1: request a reload. Honoured only in RUN.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `cpu_addr` in 12: CPU address.
- `cpu_data_out` in 8: CPU write data.
- `cpu_we` in 1: CPU write strobe.
- `cpu_ioreq` in 1: CPU I/O cycle.
- `cpu_data_in` out 8: read data to the CPU, equal to `mem_data_out`.
- `cpu_reset` out 1: reset to `grom_cpu`.
- `mem_addr` out 12: RAM address.
- `mem_data_in` out 8: RAM write data.
- `mem_we` out 1: RAM write enable.
- `mem_data_out` in 8: RAM read data.
- `busy` out 1: high in any state except RUN.
- `load_done` out 1: one-cycle pulse when the loader enters RUN after a load.

## Operation
- Handshake: a byte transfers when `rx_valid & rx_ready`. `rx_ready` is high only in LEN_LO, LEN_HI and DATA.
- Stream format: length low byte, then length high byte, then N data bytes.
  - N = {hi[4:0], lo}; hi[7:5] are ignored.
  - N > 4096 saturates to 4096.
- FSM states: LEN_LO, LEN_HI, DATA, RELEASE, RUN.
- LEN_LO → LEN_HI on transfer. The low byte is latched.
- LEN_HI → DATA on transfer, with the 13-bit counter `cnt` = 0 and `len` = N.
  - If N == 0, go to RELEASE instead.
- DATA: each transfer writes `rx_data` to RAM address `cnt[11:0]` and increments `cnt`.
  - The transfer that makes `cnt` reach `len` moves the FSM to RELEASE.
  - Addresses never wrap: the maximum is 4095, written when N = 4096.
- RELEASE: a hold counter runs for RESET_HOLD cycles, then the FSM goes to RUN.
- RUN: `load_start` moves the FSM to LEN_LO.
- RAM port in RUN (combinational pass-through):
  - `mem_addr` = `cpu_addr`, `mem_data_in` = `cpu_data_out`.
  - `mem_we` = `cpu_we & ~cpu_ioreq`. I/O writes never reach RAM.
- RAM port in LEN_LO, LEN_HI, DATA and RELEASE:
  - `mem_addr` = `cnt[11:0]`, `mem_data_in` = `rx_data`.
  - `mem_we` = `rx_valid & (state == DATA)`.
  - CPU writes are ignored in these states.
- `cpu_data_in` = `mem_data_out` in all states.
- `cpu_reset` is registered: high in every state except RUN. It changes on the same edge as the state register.
- `load_start` outside RUN is ignored. A reload never aborts a load in progress.

## Timing
- Reset values:
  - `cpu_reset` = 1, `busy` = 1, `load_done` = 0, `rx_ready` = 0, `cnt` = 0.
  - The FSM holds RELEASE with the hold counter cleared.
- First cycle after reset is released:
  - `BOOT_ON_RESET` = 1: state LEN_LO.
  - `BOOT_ON_RESET` = 0: state RELEASE, then RUN after RESET_HOLD cycles.
- Throughput: one byte per cycle. There are no bubbles between header and data.
- A data byte accepted in cycle k is written into RAM at the rising edge ending cycle k.
- Last byte accepted in cycle k:
  - cycles k+1 … k+RESET_HOLD: RELEASE.
  - cycle k+RESET_HOLD+1: RUN, `cpu_reset` = 0, `busy` = 0, `load_done` = 1 for that cycle only.
- `load_start` sampled high in RUN in cycle j: in cycle j+1 the state is LEN_LO and `cpu_reset` = 1. The CPU write in cycle j, if any, still reaches RAM.
- `reset` asserted mid-load: the load aborts at the next edge and RAM keeps the bytes already written. With `BOOT_ON_RESET` = 1 the loader restarts at LEN_LO and expects a new header.
- `rx_valid` low stalls any state without losing position.

## Test plan
- Reset with `BOOT_ON_RESET` = 1, stream 03 00 AA BB CC at one byte/cycle:
  - RAM[0..2] = AA BB CC.
  - `cpu_reset` falls exactly RESET_HOLD+1 cycles after the CC transfer.
  - `load_done` is a single pulse.
- Same stream with `rx_valid` toggling every other cycle: identical RAM contents, and `mem_we` asserts only on transfer cycles.
- Header 00 00: no `mem_we` at all. RUN is reached RESET_HOLD+1 cycles after the high-byte transfer.
- Header 00 FF (N saturates to 4096), incrementing data:
  - The last write goes to address 0xFFF.
  - Address 0x000 is not rewritten.
  - `rx_ready` drops after byte 4096.
- In RUN, CPU `we` = 1 with `ioreq` = 1 to address 0x010: RAM unchanged. With `ioreq` = 0: RAM[0x010] updated.
- Cases around reload and reset:
  - Pulse `load_start` in RUN: `cpu_reset` rises next cycle.
  - Pulse `load_start` again during DATA: ignored.
  - Assert `reset` after 2 data bytes: restart at LEN_LO, and a new 01 00 55 stream writes RAM[0] = 55.
